mips_multi_ctrl_hs: RTL and testbench

//  Next-generation multicycle MIPS control unit: Moore FSM plus ALU decoder for the multicycle datapath.

---
 rtl/mips_multi_ctrl_hs.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_multi_ctrl_hs.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_ctrl_hs.sv
// Multicycle MIPS control unit: Moore FSM with memory ready handshake, wait timeout and ALU decoder.
// Optional ILLEGAL_TRAP_EN: illegal op/funct parks the FSM in TRAP instead of skipping to FETCH.
module mips_multi_ctrl_hs #(
    parameter int TIMEOUT = 16,
    parameter int WAIT_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       zeroext,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       memerr,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    state_t            state_reg, state_next, dec_state;
    logic [WAIT_W-1:0] waitcnt_reg;
    logic              memerr_reg;
    logic              is_mem_state;
    logic              funct_ok;
    logic [2:0]        funct_alu;
    logic              pcen_dec, memread_dec, memwrite_dec, irwrite_dec, regwrite_dec;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // While reset is high the outputs decode as FETCH; strobes are gated separately below.
    assign dec_state    = reset ? S_FETCH : state_reg;
    assign is_mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);

    always_comb begin
        state_next   = state_reg;
        pcen_dec     = 1'b0;
        memread_dec  = 1'b0;
        memwrite_dec = 1'b0;
        irwrite_dec  = 1'b0;
        regwrite_dec = 1'b0;
        alusrca      = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        zeroext      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = ALU_ADD;
        case (dec_state)
            S_FETCH: begin
                memread_dec = 1'b1;
                alusrcb     = 2'b01;
                if (mem_ready) begin
                    irwrite_dec = 1'b1;
                    pcen_dec    = 1'b1;
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:                      state_next = S_MEMADR;
                    OP_R:                              state_next = S_RTYPEEX;
                    OP_BEQ:                            state_next = S_BEQEX;
                    OP_BNE:                            state_next = S_BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IMMEX;
                    OP_J:                              state_next = S_JEX;
                    default:                           state_next = ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread_dec = 1'b1;
                iord        = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_dec = 1'b1;
                memtoreg     = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWR: begin
                memwrite_dec = 1'b1;
                iord         = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_next = funct_ok ? S_RTYPEWB : ILLEGAL_NEXT;
            end
            S_RTYPEWB: begin
                regwrite_dec = 1'b1;
                regdst       = 1'b1;
                state_next   = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen_dec   = (dec_state == S_BEQEX) ? zero : ~zero;
                state_next = S_FETCH;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin alucontrol = ALU_AND; zeroext = 1'b1; end
                    OP_ORI:  begin alucontrol = ALU_OR;  zeroext = 1'b1; end
                    OP_SLTI: alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_dec = 1'b1;
                state_next   = S_FETCH;
            end
            S_JEX: begin
                pcsrc      = 2'b10;
                pcen_dec   = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            waitcnt_reg <= '0;
            memerr_reg  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            trap_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            // Saturate at TIMEOUT so a very long stall cannot wrap the counter.
            if (is_mem_state && !mem_ready) begin
                if (waitcnt_reg != TIMEOUT_W) waitcnt_reg <= waitcnt_reg + 1'b1;
            end else begin
                waitcnt_reg <= '0;
            end
            if (waitcnt_reg == TIMEOUT_W) memerr_reg <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
            if (state_next == S_TRAP) trap_reg <= 1'b1;
`endif
        end
    end

    assign pcen     = pcen_dec     & ~reset;
    assign memread  = memread_dec  & ~reset;
    assign memwrite = memwrite_dec & ~reset;
    assign irwrite  = irwrite_dec  & ~reset;
    assign regwrite = regwrite_dec & ~reset;
    assign memerr   = memerr_reg;
    assign state    = state_reg;
`ifdef ILLEGAL_TRAP_EN
    assign trap     = trap_reg;
`else
    assign trap     = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multi_ctrl_hs.sv
// Scoreboard bench for mips_multi_ctrl_hs: each step drives inputs and queues the expected outputs,
// which are popped and compared mid-cycle on the falling edge.
module tb_mips_multi_ctrl_hs;

    localparam int TIMEOUT = 16;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

    // strobes {pcen, memread, memwrite, irwrite, regwrite}
    localparam logic [4:0] B_NONE = 5'b00000, B_FWAIT = 5'b01000, B_FGO = 5'b11010;
    localparam logic [4:0] B_PC = 5'b10000, B_MWR = 5'b00100, B_RW = 5'b00001, B_MRD = 5'b01000;

    // selects {alusrca, iord, memtoreg, regdst, zeroext, alusrcb, pcsrc, alucontrol}
    localparam logic [11:0] M_FETCH  = {5'b00000, 2'b01, 2'b00, 3'b010};
    localparam logic [11:0] M_DECODE = {5'b00000, 2'b11, 2'b00, 3'b010};
    localparam logic [11:0] M_MEMADR = {5'b10000, 2'b10, 2'b00, 3'b010};
    localparam logic [11:0] M_MEMACC = {5'b01000, 2'b00, 2'b00, 3'b010};
    localparam logic [11:0] M_MEMWB  = {5'b00100, 2'b00, 2'b00, 3'b010};
    localparam logic [11:0] M_RTWB   = {5'b00010, 2'b00, 2'b00, 3'b010};
    localparam logic [11:0] M_IDLE   = {5'b00000, 2'b00, 2'b00, 3'b010};
    localparam logic [11:0] M_BR     = {5'b10000, 2'b00, 2'b01, 3'b110};
    localparam logic [11:0] M_JEX    = {5'b00000, 2'b00, 2'b10, 3'b010};

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [4:0]  stb;
        logic [11:0] mx;
        logic        err;
        logic        trp;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = OP_LW;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, zeroext;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       memerr, trap;
    logic [3:0] state;

    int    checks = 0;
    int    failures = 0;
    step_t exp_q[$];

    logic [4:0]  obs_stb;
    logic [11:0] obs_mx;
    logic [22:0] obs;
    assign obs_stb = {pcen, memread, memwrite, irwrite, regwrite};
    assign obs_mx  = {alusrca, iord, memtoreg, regdst, zeroext, alusrcb, pcsrc, alucontrol};
    assign obs     = {state, obs_stb, obs_mx, memerr, trap};

    always #5 clk = ~clk;

    mips_multi_ctrl_hs #(.TIMEOUT(TIMEOUT), .WAIT_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .zeroext(zeroext),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .memerr(memerr), .trap(trap),
        .state(state)
    );

    function automatic step_t mk(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input logic rd, input logic [3:0] s, input logic [4:0] b,
                                 input logic [11:0] m, input logic e, input logic t);
        step_t x;
        x = '{rst: r, op: o, funct: f, zero: z, rdy: rd, st: s, stb: b, mx: m, err: e, trp: t};
        return x;
    endfunction

    function automatic logic [11:0] m_rtex(input logic [2:0] alu);
        return {5'b10000, 2'b00, 2'b00, alu};
    endfunction

    function automatic logic [11:0] m_immex(input logic z, input logic [2:0] alu);
        return {4'b1000, z, 2'b10, 2'b00, alu};
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue what the DUT should show.
    task automatic apply(input step_t s);
        @(posedge clk);
        #1;
        reset = s.rst; op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
        exp_q.push_back(s);
    endtask

    task automatic test_reset;
        step_t plan[$];
        step_t e;
        plan.push_back(mk(1, OP_LW, 0, 0, 1, 0, B_NONE, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 1, 0, B_FGO, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 1, 1, B_NONE, M_DECODE, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 0, 2, B_NONE, M_MEMADR, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 0, 3, B_MRD, M_MEMACC, 0, 0));
        plan.push_back(mk(1, OP_LW, 0, 0, 0, 3, B_NONE, M_FETCH, 0, 0));
        plan.push_back(mk(1, OP_LW, 0, 0, 0, 0, B_NONE, M_FETCH, 0, 0));
        plan.push_back(mk(1, OP_LW, 0, 0, 0, 0, B_NONE, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 0, 0, B_FWAIT, M_FETCH, 0, 0));
        foreach (plan[i]) begin
            apply(plan[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== {e.st, e.stb, e.mx, e.err, e.trp}) begin
                failures++;
                $display("FAIL reset[%0d] got st=%0d stb=%b mx=%b err=%b trap=%b want st=%0d stb=%b mx=%b err=%b trap=%b",
                         i, state, obs_stb, obs_mx, memerr, trap, e.st, e.stb, e.mx, e.err, e.trp);
            end
        end
    endtask

    task automatic test_lw;
        step_t plan[$];
        step_t e;
        plan.push_back(mk(0, OP_LW, 0, 0, 1, 0, B_FGO, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 1, 1, B_NONE, M_DECODE, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 1, 2, B_NONE, M_MEMADR, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 1, 3, B_MRD, M_MEMACC, 0, 0));
        plan.push_back(mk(0, OP_LW, 0, 0, 1, 4, B_RW, M_MEMWB, 0, 0));
        foreach (plan[i]) begin
            apply(plan[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== {e.st, e.stb, e.mx, e.err, e.trp}) begin
                failures++;
                $display("FAIL lw[%0d] got st=%0d stb=%b mx=%b err=%b trap=%b want st=%0d stb=%b mx=%b err=%b trap=%b",
                         i, state, obs_stb, obs_mx, memerr, trap, e.st, e.stb, e.mx, e.err, e.trp);
            end
        end
    endtask

    task automatic test_fetch_wait;
        step_t plan[$];
        step_t e;
        for (int k = 0; k < 3; k++) plan.push_back(mk(0, OP_J, 0, 0, 0, 0, B_FWAIT, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_J, 0, 0, 1, 0, B_FGO, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_J, 0, 0, 0, 1, B_NONE, M_DECODE, 0, 0));
        plan.push_back(mk(0, OP_J, 0, 0, 0, 11, B_PC, M_JEX, 0, 0));
        foreach (plan[i]) begin
            apply(plan[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== {e.st, e.stb, e.mx, e.err, e.trp}) begin
                failures++;
                $display("FAIL fetch_wait[%0d] got st=%0d stb=%b mx=%b err=%b trap=%b want st=%0d stb=%b mx=%b err=%b trap=%b",
                         i, state, obs_stb, obs_mx, memerr, trap, e.st, e.stb, e.mx, e.err, e.trp);
            end
        end
    endtask

    task automatic test_branch;
        step_t plan[$];
        step_t e;
        logic [5:0] bop[4]  = '{OP_BNE, OP_BNE, OP_BEQ, OP_BEQ};
        logic       bz[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] bst[4]  = '{4'd12, 4'd12, 4'd8, 4'd8};
        logic [4:0] bstb[4] = '{B_PC, B_NONE, B_PC, B_NONE};
        for (int k = 0; k < 4; k++) begin
            plan.push_back(mk(0, bop[k], 0, bz[k], 1, 0, B_FGO, M_FETCH, 0, 0));
            plan.push_back(mk(0, bop[k], 0, bz[k], 1, 1, B_NONE, M_DECODE, 0, 0));
            plan.push_back(mk(0, bop[k], 0, bz[k], 1, bst[k], bstb[k], M_BR, 0, 0));
        end
        foreach (plan[i]) begin
            apply(plan[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== {e.st, e.stb, e.mx, e.err, e.trp}) begin
                failures++;
                $display("FAIL branch[%0d] got st=%0d stb=%b mx=%b err=%b trap=%b want st=%0d stb=%b mx=%b err=%b trap=%b",
                         i, state, obs_stb, obs_mx, memerr, trap, e.st, e.stb, e.mx, e.err, e.trp);
            end
        end
    endtask

    task automatic test_alu_ops;
        step_t plan[$];
        step_t e;
        logic [5:0]  iop[4]  = '{OP_ORI, OP_SLTI, OP_ANDI, OP_ADDI};
        logic [11:0] imx[4]  = '{m_immex(1'b1, 3'b001), m_immex(1'b0, 3'b111),
                                 m_immex(1'b1, 3'b000), m_immex(1'b0, 3'b010)};
        logic [5:0]  rfn[2]  = '{6'b100010, 6'b101010};
        logic [11:0] rmx[2]  = '{m_rtex(3'b110), m_rtex(3'b111)};
        for (int k = 0; k < 4; k++) begin
            plan.push_back(mk(0, iop[k], 0, 0, 1, 0, B_FGO, M_FETCH, 0, 0));
            plan.push_back(mk(0, iop[k], 0, 0, 1, 1, B_NONE, M_DECODE, 0, 0));
            plan.push_back(mk(0, iop[k], 0, 0, 1, 9, B_NONE, imx[k], 0, 0));
            plan.push_back(mk(0, iop[k], 0, 0, 1, 10, B_RW, M_IDLE, 0, 0));
        end
        for (int k = 0; k < 2; k++) begin
            plan.push_back(mk(0, OP_R, rfn[k], 0, 1, 0, B_FGO, M_FETCH, 0, 0));
            plan.push_back(mk(0, OP_R, rfn[k], 0, 1, 1, B_NONE, M_DECODE, 0, 0));
            plan.push_back(mk(0, OP_R, rfn[k], 0, 1, 6, B_NONE, rmx[k], 0, 0));
            plan.push_back(mk(0, OP_R, rfn[k], 0, 1, 7, B_RW, M_RTWB, 0, 0));
        end
        foreach (plan[i]) begin
            apply(plan[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== {e.st, e.stb, e.mx, e.err, e.trp}) begin
                failures++;
                $display("FAIL alu_ops[%0d] got st=%0d stb=%b mx=%b err=%b trap=%b want st=%0d stb=%b mx=%b err=%b trap=%b",
                         i, state, obs_stb, obs_mx, memerr, trap, e.st, e.stb, e.mx, e.err, e.trp);
            end
        end
    endtask

    task automatic test_timeout;
        step_t plan[$];
        step_t e;
        plan.push_back(mk(0, OP_SW, 0, 0, 1, 0, B_FGO, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_SW, 0, 0, 1, 1, B_NONE, M_DECODE, 0, 0));
        plan.push_back(mk(0, OP_SW, 0, 0, 1, 2, B_NONE, M_MEMADR, 0, 0));
        // After TIMEOUT stalled cycles the counter hits TIMEOUT; memerr shows one edge later.
        for (int k = 0; k < TIMEOUT + 2; k++)
            plan.push_back(mk(0, OP_SW, 0, 0, 0, 5, B_MWR, M_MEMACC, (k >= TIMEOUT + 1), 0));
        plan.push_back(mk(0, OP_SW, 0, 0, 1, 5, B_MWR, M_MEMACC, 1, 0));
        plan.push_back(mk(0, OP_SW, 0, 0, 0, 0, B_FWAIT, M_FETCH, 1, 0));
        foreach (plan[i]) begin
            apply(plan[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== {e.st, e.stb, e.mx, e.err, e.trp}) begin
                failures++;
                $display("FAIL timeout[%0d] got st=%0d stb=%b mx=%b err=%b trap=%b want st=%0d stb=%b mx=%b err=%b trap=%b",
                         i, state, obs_stb, obs_mx, memerr, trap, e.st, e.stb, e.mx, e.err, e.trp);
            end
        end
    endtask

    task automatic test_illegal;
        step_t plan[$];
        step_t e;
        plan.push_back(mk(0, OP_BAD, 0, 0, 1, 0, B_FGO, M_FETCH, 1, 0));
        plan.push_back(mk(0, OP_BAD, 0, 0, 1, 1, B_NONE, M_DECODE, 1, 0));
`ifdef ILLEGAL_TRAP_EN
        plan.push_back(mk(0, OP_BAD, 0, 0, 1, 13, B_NONE, M_IDLE, 1, 1));
        plan.push_back(mk(0, OP_BAD, 0, 0, 1, 13, B_NONE, M_IDLE, 1, 1));
        plan.push_back(mk(1, OP_R, 6'b111111, 0, 1, 13, B_NONE, M_FETCH, 1, 1));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 1, 0, B_FGO, M_FETCH, 0, 0));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 1, 1, B_NONE, M_DECODE, 0, 0));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 1, 6, B_NONE, m_rtex(3'b010), 0, 0));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 1, 13, B_NONE, M_IDLE, 0, 1));
        plan.push_back(mk(1, OP_R, 6'b111111, 0, 0, 13, B_NONE, M_FETCH, 0, 1));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 0, 0, B_FWAIT, M_FETCH, 0, 0));
`else
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 1, 0, B_FGO, M_FETCH, 1, 0));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 1, 1, B_NONE, M_DECODE, 1, 0));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 1, 6, B_NONE, m_rtex(3'b010), 1, 0));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 0, 0, B_FWAIT, M_FETCH, 1, 0));
        plan.push_back(mk(1, OP_R, 6'b111111, 0, 0, 0, B_NONE, M_FETCH, 1, 0));
        plan.push_back(mk(0, OP_R, 6'b111111, 0, 0, 0, B_FWAIT, M_FETCH, 0, 0));
`endif
        foreach (plan[i]) begin
            apply(plan[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== {e.st, e.stb, e.mx, e.err, e.trp}) begin
                failures++;
                $display("FAIL illegal[%0d] got st=%0d stb=%b mx=%b err=%b trap=%b want st=%0d stb=%b mx=%b err=%b trap=%b",
                         i, state, obs_stb, obs_mx, memerr, trap, e.st, e.stb, e.mx, e.err, e.trp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_fetch_wait;
        test_branch;
        test_alu_ops;
        test_timeout;
        test_illegal;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
